k12_nonce_dispatcher: RTL and testbench
=======================================

# k12_nonce_dispatcher

Upstream work stage for the K12 proof-of-work hasher. It accepts a mining job (blob, target, starting nonce, nonce count), issues one `load` pulse with an incrementing nonce to the hasher every `HASH_INTERVAL` cycles, and tags each hasher `store` with the nonce that produced it. Matching nonce/hash pairs go into a small result FIFO, which the host-side interface drains.

## Interface
- `HASH_INTERVAL`, default 4: cycles between successive hasher `load` pulses; must be at least 1.
- `HASH_LATENCY`, default 24: fixed cycles from a `load` pulse to that nonce's `store` sample; must be at least 1.
- `RES_DEPTH`, default 4: result FIFO entries; must be a power of two.
- `clk`  in  1  sole clock; all logic is rising-edge.
- `rst`  in  1  asynchronous, active-low reset.
- `job_valid`  in  1  a job is offered.
- `job_ready`  out  1  the dispatcher can accept a job.
- `job_blob`  in  576  hashing blob.
- `job_target`  in  64  difficulty target.
- `job_nonce`  in  64  first nonce.
- `job_count`  in  32  number of nonces to try.
- `abort`  in  1  stops issuing immediately and drains.
- `job_done`  out  1  one-cycle pulse when a job fully retires.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `hash_load`  out  1  one-cycle start pulse to the hasher.
- `hash_blob`  out  576  latched blob.
- `hash_target`  out  64  latched target.
- `hash_nonce`  out  64  nonce for the current `hash_load`.
- `hash_store`  in  1  hasher reports hash below target.
- `hash_value`  in  256  hasher output hash.
- `res_valid`  out  1  result FIFO is not empty.
- `res_ready`  in  1  consumer pops the head.
- `res_nonce`  out  64  nonce at the FIFO head.
- `res_hash`  out  256  hash at the FIFO head.
- `res_overflow`  out  1  sticky flag; a result was dropped.
- `hash_issued`  out  32  count of nonces issued in the current job.

## Operation
- The FSM has three states: IDLE, RUN, DRAIN.
- **IDLE**
  - `job_ready` is 1.
  - On `job_valid && job_ready`: latch blob, target, nonce and count; clear `hash_issued`.
  - If `job_count != 0`, go to RUN. Otherwise go to DRAIN with a drain counter of 0, so `job_done` pulses on the next cycle.
- **RUN**
  - An interval counter counts 0..`HASH_INTERVAL`-1. `hash_load` asserts when the counter is 0; the first pulse comes in the first RUN cycle.
  - Each pulse drives `hash_nonce` to the current nonce, then nonce += 1 (64-bit wrap, 0xFFFF_FFFF_FFFF_FFFF → 0), remaining -= 1 and `hash_issued` += 1.
  - When remaining reaches 0 after a pulse, go to DRAIN with the drain counter set to `HASH_LATENCY`.
- **DRAIN**
  - No pulses are issued. The drain counter decrements each cycle.
  - When the counter reaches 0: pulse `job_done`, go to IDLE.
- **abort**
  - In RUN: no pulse in that cycle; go to DRAIN with counter = `HASH_LATENCY`.
  - In DRAIN or IDLE: ignored.
  - Results already in flight are still captured.
- **Tagging**
  - A delay line of `HASH_LATENCY` stages carries {valid, nonce} and advances every cycle. Stage 0 is loaded with {`hash_load`, `hash_nonce`}.
  - When `hash_store` is 1 and the tail entry is valid, push {tail nonce, `hash_value`} into the FIFO.
  - `hash_store` with an invalid tail is ignored.
- **Result FIFO**
  - Push when full with no pop: the entry is dropped and `res_overflow` sets. Only reset clears `res_overflow`.
  - Push and pop in the same cycle when full: both take effect.
  - Pop when empty: no effect.
- `job_blob` and `job_target` are sampled only at acceptance. `hash_blob` and `hash_target` stay stable until the next job.

## Timing
- Reset values:
  - State IDLE.
  - `job_ready`=1.
  - `busy`, `hash_load`, `job_done`, `res_valid`, `res_overflow` = 0.
  - `hash_blob`, `hash_target`, `hash_nonce`, `res_nonce`, `res_hash`, `hash_issued` = 0.
  - The delay line and FIFO are empty.
- Job accepted at edge N: first `hash_load` is high in cycle N+1. Pulse k (0-based) is in cycle N+1+k·`HASH_INTERVAL`.
- The matching `store` is sampled `HASH_LATENCY` cycles after its `load` cycle. `res_valid` rises one cycle after that sample.
- `job_done` comes `HASH_LATENCY`+1 cycles after the last pulse, or after abort.
- Reset mid-job: everything returns to reset values at once, including dropping pending results.

## Structure
- Shared package `k12_pkg`:
  - `K12_BLOB_W`=576, `K12_NONCE_W`=64, `K12_TARGET_W`=64, `K12_HASH_W`=256.
  - The state enum.
- One sub-module, `k12_result_fifo`: synchronous FIFO parameterized by width and depth, with valid/ready outputs and a full flag.

## Test plan
- Job with blob 0x03b2…0808, target 0x24a67fcd, nonce 0x2c9146afa, count 3, `HASH_INTERVAL`=4 → `hash_load` at N+1, N+5, N+9 with nonces …afa, …afb, …afc. `job_done` at N+9+`HASH_LATENCY`+1.
- Model hasher asserts `store` for nonce …afb only → exactly one FIFO entry {0x2c9146afb, hash}, with `res_valid` held until `res_ready`.
- `job_nonce`=0xFFFF_FFFF_FFFF_FFFE, count 3 → nonces …FFFE, …FFFF, 0x0.
- `store` on 6 consecutive loads with `res_ready`=0 and `RES_DEPTH`=4 → 4 entries kept, `res_overflow`=1; pop all → first four nonces returned in order.
- `abort` after the 2nd pulse of a count-100 job → no further pulses, `hash_issued`=2, in-flight stores still captured, `job_done` after drain.
- `job_count`=0 → no `hash_load`, `job_done` the cycle after acceptance. Reset asserted mid-RUN → all outputs at reset values immediately.

Source files
------------

// File: rtl/k12_pkg.sv
// k12_pkg
//    Shared widths and the dispatcher state encoding for the K12 nonce
//    dispatch stage. Imported by every file of this slice.
package k12_pkg;

    localparam int K12_BLOB_W   = 576;
    localparam int K12_NONCE_W  = 64;
    localparam int K12_TARGET_W = 64;
    localparam int K12_HASH_W   = 256;

    // Dispatcher FSM: IDLE waits for a job, RUN issues nonces, DRAIN waits
    // for the hasher pipeline to empty before the job is retired.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } k12_state_e;

endpackage

// File: rtl/k12_result_fifo.sv
// k12_result_fifo
//    Small synchronous FIFO holding nonce/hash results for the host.
//    A push while full is refused unless a pop happens in the same cycle;
//    a pop while empty does nothing.
//
// Ports
//    clk, rst_n   rising-edge clock, asynchronous active-low reset
//    push_i       write request, wdata_i is the entry to store
//    ready_i      consumer pops the head when valid_o is high
//    valid_o      FIFO holds at least one entry
//    rdata_o      head entry (zero while empty)
//    full_o       every slot is occupied
module k12_result_fifo
    import k12_pkg::*;
#(
    parameter int WIDTH = K12_NONCE_W + K12_HASH_W,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr_q;
    logic [AW-1:0]    rdPtr_q;
    logic [CW-1:0]    count_q;
    logic             popEn;
    logic             pushEn;

    assign valid_o = (count_q != '0);
    assign full_o  = (count_q == FULL_CNT);
    assign popEn   = ready_i && valid_o;
    // A simultaneous pop frees the slot, so a full FIFO still accepts then.
    assign pushEn  = push_i && (!full_o || popEn);
    assign rdata_o = valid_o ? mem[rdPtr_q] : '0;

    // Pointer and occupancy bookkeeping; pointers wrap explicitly so any
    // depth works.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (pushEn) begin
                wrPtr_q <= (wrPtr_q == LAST_PTR) ? '0 : wrPtr_q + 1'b1;
            end
            if (popEn) begin
                rdPtr_q <= (rdPtr_q == LAST_PTR) ? '0 : rdPtr_q + 1'b1;
            end
            case ({pushEn, popEn})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: nothing is visible until count_q says so.
    always_ff @(posedge clk) begin
        if (pushEn) begin
            mem[wrPtr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/k12_nonce_dispatcher.sv
// k12_nonce_dispatcher
//    Feeds the K12 hasher with a job's nonces, one load pulse every
//    HASH_INTERVAL cycles, and tags each hasher store with the nonce that
//    produced it via a HASH_LATENCY-deep delay line. Tagged results are
//    queued in a small FIFO for the host.
//
// Ports
//    clk, rst_n                 rising-edge clock, asynchronous active-low reset
//    job_valid_i/job_ready_o    job handshake; job_blob_i, job_target_i,
//                               job_nonce_i, job_count_i sampled on acceptance
//    abort_i                    stop issuing and drain (only acts in RUN)
//    job_done_o                 one-cycle pulse when the job retires
//    busy_o                     FSM is not idle
//    hash_load_o                start pulse to hasher, with hash_nonce_o
//    hash_blob_o, hash_target_o job data latched at acceptance
//    hash_store_i, hash_value_i hasher reports a hash below target
//    res_valid_o/res_ready_i    result FIFO head handshake
//    res_nonce_o, res_hash_o    result FIFO head contents
//    res_overflow_o             sticky: a result was dropped on a full FIFO
//    hash_issued_o              nonces issued in the current job
module k12_nonce_dispatcher
    import k12_pkg::*;
#(
    parameter int HASH_INTERVAL = 4,
    parameter int HASH_LATENCY  = 24,
    parameter int RES_DEPTH     = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    job_valid_i,
    output logic                    job_ready_o,
    input  logic [K12_BLOB_W-1:0]   job_blob_i,
    input  logic [K12_TARGET_W-1:0] job_target_i,
    input  logic [K12_NONCE_W-1:0]  job_nonce_i,
    input  logic [31:0]             job_count_i,
    input  logic                    abort_i,
    output logic                    job_done_o,
    output logic                    busy_o,
    output logic                    hash_load_o,
    output logic [K12_BLOB_W-1:0]   hash_blob_o,
    output logic [K12_TARGET_W-1:0] hash_target_o,
    output logic [K12_NONCE_W-1:0]  hash_nonce_o,
    input  logic                    hash_store_i,
    input  logic [K12_HASH_W-1:0]   hash_value_i,
    output logic                    res_valid_o,
    input  logic                    res_ready_i,
    output logic [K12_NONCE_W-1:0]  res_nonce_o,
    output logic [K12_HASH_W-1:0]   res_hash_o,
    output logic                    res_overflow_o,
    output logic [31:0]             hash_issued_o
);

    localparam int IW    = (HASH_INTERVAL > 1) ? $clog2(HASH_INTERVAL) : 1;
    localparam int DW    = $clog2(HASH_LATENCY + 1);
    localparam int RES_W = K12_NONCE_W + K12_HASH_W;
    localparam logic [IW-1:0] INTERVAL_LAST = IW'(HASH_INTERVAL - 1);
    localparam logic [DW-1:0] DRAIN_START   = DW'(HASH_LATENCY);

    k12_state_e              state_q;
    logic [IW-1:0]           intervalCnt_q;
    logic [DW-1:0]           drainCnt_q;
    logic [31:0]             remaining_q;
    logic [31:0]             issued_q;
    logic [K12_NONCE_W-1:0]  nonce_q;
    logic [K12_BLOB_W-1:0]   blob_q;
    logic [K12_TARGET_W-1:0] target_q;

    logic                    pipeValid_q [HASH_LATENCY];
    logic [K12_NONCE_W-1:0]  pipeNonce_q [HASH_LATENCY];

    logic                    issueLoad;
    logic                    resPush;
    logic                    resPop;
    logic                    fifoFull;
    logic [RES_W-1:0]        fifoRdata;
    logic                    overflow_q;

    // An abort in the same cycle suppresses the pulse, hence the direct
    // dependence on abort_i.
    assign issueLoad = (state_q == ST_RUN) && (intervalCnt_q == '0) && !abort_i;

    assign hash_load_o   = issueLoad;
    assign hash_nonce_o  = nonce_q;
    assign hash_blob_o   = blob_q;
    assign hash_target_o = target_q;
    assign hash_issued_o = issued_q;
    assign job_ready_o   = (state_q == ST_IDLE);
    assign busy_o        = (state_q != ST_IDLE);
    assign job_done_o    = (state_q == ST_DRAIN) && (drainCnt_q == '0);

    // Dispatcher FSM. nonce_q always holds the next nonce to issue, so it
    // is exactly the value presented with each load pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            intervalCnt_q <= '0;
            drainCnt_q    <= '0;
            remaining_q   <= '0;
            issued_q      <= '0;
            nonce_q       <= '0;
            blob_q        <= '0;
            target_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (job_valid_i) begin
                        blob_q        <= job_blob_i;
                        target_q      <= job_target_i;
                        nonce_q       <= job_nonce_i;
                        remaining_q   <= job_count_i;
                        issued_q      <= '0;
                        intervalCnt_q <= '0;
                        drainCnt_q    <= '0;
                        state_q       <= (job_count_i != '0) ? ST_RUN : ST_DRAIN;
                    end
                end
                ST_RUN: begin
                    if (abort_i) begin
                        drainCnt_q <= DRAIN_START;
                        state_q    <= ST_DRAIN;
                    end else begin
                        intervalCnt_q <= (intervalCnt_q == INTERVAL_LAST) ? '0
                                                                          : intervalCnt_q + 1'b1;
                        if (issueLoad) begin
                            nonce_q     <= nonce_q + 1'b1;
                            remaining_q <= remaining_q - 1'b1;
                            issued_q    <= issued_q + 1'b1;
                            if (remaining_q == 32'd1) begin
                                drainCnt_q <= DRAIN_START;
                                state_q    <= ST_DRAIN;
                            end
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drainCnt_q == '0) begin
                        state_q <= ST_IDLE;
                    end else begin
                        drainCnt_q <= drainCnt_q - 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Tag delay line: the tail holds the nonce loaded HASH_LATENCY cycles
    // ago, which is the nonce the current hash_store belongs to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < HASH_LATENCY; i++) begin
                pipeValid_q[i] <= 1'b0;
                pipeNonce_q[i] <= '0;
            end
        end else begin
            pipeValid_q[0] <= issueLoad;
            pipeNonce_q[0] <= nonce_q;
            for (int i = 1; i < HASH_LATENCY; i++) begin
                pipeValid_q[i] <= pipeValid_q[i-1];
                pipeNonce_q[i] <= pipeNonce_q[i-1];
            end
        end
    end

    // Stores without a matching load in the tail are stray and dropped.
    assign resPush = hash_store_i && pipeValid_q[HASH_LATENCY-1];
    assign resPop  = res_ready_i && res_valid_o;

    k12_result_fifo #(
        .WIDTH (RES_W),
        .DEPTH (RES_DEPTH)
    ) u_result_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (resPush),
        .wdata_i ({pipeNonce_q[HASH_LATENCY-1], hash_value_i}),
        .ready_i (res_ready_i),
        .valid_o (res_valid_o),
        .rdata_o (fifoRdata),
        .full_o  (fifoFull)
    );

    assign res_nonce_o = fifoRdata[RES_W-1 -: K12_NONCE_W];
    assign res_hash_o  = fifoRdata[K12_HASH_W-1:0];

    // Overflow is sticky until reset: a result lost here cannot be recovered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else if (resPush && fifoFull && !resPop) begin
            overflow_q <= 1'b1;
        end
    end

    assign res_overflow_o = overflow_q;

endmodule

// File: tb/tb_k12_nonce_dispatcher.sv
// tb_k12_nonce_dispatcher
//    Directed bench for k12_nonce_dispatcher with a small model hasher that
//    answers each load HASH_LATENCY cycles later.
module tb_k12_nonce_dispatcher;
    import k12_pkg::*;

    localparam int HASH_INTERVAL = 4;
    localparam int HASH_LATENCY  = 24;
    localparam int RES_DEPTH     = 4;

    logic                    clk;
    logic                    rst_n;
    logic                    job_valid_i;
    logic                    job_ready_o;
    logic [K12_BLOB_W-1:0]   job_blob_i;
    logic [K12_TARGET_W-1:0] job_target_i;
    logic [K12_NONCE_W-1:0]  job_nonce_i;
    logic [31:0]             job_count_i;
    logic                    abort_i;
    logic                    job_done_o;
    logic                    busy_o;
    logic                    hash_load_o;
    logic [K12_BLOB_W-1:0]   hash_blob_o;
    logic [K12_TARGET_W-1:0] hash_target_o;
    logic [K12_NONCE_W-1:0]  hash_nonce_o;
    logic                    hash_store_i;
    logic [K12_HASH_W-1:0]   hash_value_i;
    logic                    res_valid_o;
    logic                    res_ready_i;
    logic [K12_NONCE_W-1:0]  res_nonce_o;
    logic [K12_HASH_W-1:0]   res_hash_o;
    logic                    res_overflow_o;
    logic [31:0]             hash_issued_o;

    typedef struct {
        logic [63:0] nonce;
        int          due;
    } pending_t;

    pending_t    pending[$];
    int          cyc;
    int          storeMode;
    logic [63:0] winNonce;
    logic        forceStore;
    int          checksTotal;
    int          checksPassed;
    logic [575:0] blobA;

    k12_nonce_dispatcher #(
        .HASH_INTERVAL (HASH_INTERVAL),
        .HASH_LATENCY  (HASH_LATENCY),
        .RES_DEPTH     (RES_DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .job_valid_i    (job_valid_i),
        .job_ready_o    (job_ready_o),
        .job_blob_i     (job_blob_i),
        .job_target_i   (job_target_i),
        .job_nonce_i    (job_nonce_i),
        .job_count_i    (job_count_i),
        .abort_i        (abort_i),
        .job_done_o     (job_done_o),
        .busy_o         (busy_o),
        .hash_load_o    (hash_load_o),
        .hash_blob_o    (hash_blob_o),
        .hash_target_o  (hash_target_o),
        .hash_nonce_o   (hash_nonce_o),
        .hash_store_i   (hash_store_i),
        .hash_value_i   (hash_value_i),
        .res_valid_o    (res_valid_o),
        .res_ready_i    (res_ready_i),
        .res_nonce_o    (res_nonce_o),
        .res_hash_o     (res_hash_o),
        .res_overflow_o (res_overflow_o),
        .hash_issued_o  (hash_issued_o)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter used by the model hasher to schedule its answers.
    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Deterministic stand-in for the hash of a nonce.
    function automatic logic [255:0] hashOf(input logic [63:0] n);
        return {n ^ 64'hDEAD_BEEF_0BAD_F00D, ~n, n, 64'h0123_4567_89AB_CDEF};
    endfunction

    // Model hasher: remembers each load seen mid-cycle and answers it
    // HASH_LATENCY cycles later, storing only the nonces storeMode selects.
    initial begin : hasherModel
        pending_t head;
        hash_store_i = 1'b0;
        hash_value_i = '0;
        forever begin
            @(negedge clk);
            hash_store_i = 1'b0;
            hash_value_i = '0;
            if (pending.size() > 0 && pending[0].due == cyc) begin
                head = pending.pop_front();
                if (storeMode == 2 || (storeMode == 1 && head.nonce == winNonce)) begin
                    hash_store_i = 1'b1;
                    hash_value_i = hashOf(head.nonce);
                end
            end
            if (hash_load_o) begin
                pending.push_back('{nonce: hash_nonce_o, due: cyc + HASH_LATENCY});
            end
            if (forceStore) begin
                hash_store_i = 1'b1;
                hash_value_i = hashOf(64'hFFFF);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [575:0] observed,
                               input logic [575:0] expected);
        checksTotal++;
        assert (observed === expected) checksPassed++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    // Offers one job from an idle cycle; returns in the first cycle after
    // acceptance with the job inputs scrambled to prove they were latched.
    task automatic applyStimulus(input logic [575:0] blob, input logic [63:0] target,
                                 input logic [63:0] nonce, input logic [31:0] count);
        job_blob_i   = blob;
        job_target_i = target;
        job_nonce_i  = nonce;
        job_count_i  = count;
        job_valid_i  = 1'b1;
        tick(1);
        job_valid_i  = 1'b0;
        job_blob_i   = ~blob;
        job_target_i = ~target;
        job_nonce_i  = ~nonce;
        job_count_i  = 32'd0;
    endtask

    task automatic waitForDone(input int budget, output logic found);
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (job_done_o) begin
                found = 1'b1;
                break;
            end
            tick(1);
        end
    endtask

    initial begin : mainSeq
        logic found;
        int   loads;

        blobA        = {16'h03b2, {68{8'h5a}}, 16'h0808};
        checksTotal  = 0;
        checksPassed = 0;
        storeMode    = 0;
        winNonce     = '0;
        forceStore   = 1'b0;
        rst_n        = 1'b0;
        job_valid_i  = 1'b0;
        job_blob_i   = '0;
        job_target_i = '0;
        job_nonce_i  = '0;
        job_count_i  = '0;
        abort_i      = 1'b0;
        res_ready_i  = 1'b0;

        // Reset values
        #2;
        checkOutput("rstReady",    576'(job_ready_o),    576'(1'b1));
        checkOutput("rstBusy",     576'(busy_o),         576'(1'b0));
        checkOutput("rstLoad",     576'(hash_load_o),    576'(1'b0));
        checkOutput("rstDone",     576'(job_done_o),     576'(1'b0));
        checkOutput("rstResValid", 576'(res_valid_o),    576'(1'b0));
        checkOutput("rstOverflow", 576'(res_overflow_o), 576'(1'b0));
        checkOutput("rstNonce",    576'(hash_nonce_o),   576'(64'h0));
        checkOutput("rstBlob",     576'(hash_blob_o),    576'(0));
        checkOutput("rstTarget",   576'(hash_target_o),  576'(64'h0));
        checkOutput("rstResNonce", 576'(res_nonce_o),    576'(64'h0));
        checkOutput("rstResHash",  576'(res_hash_o),     576'(256'h0));
        checkOutput("rstIssued",   576'(hash_issued_o),  576'(32'h0));
        #10;
        rst_n = 1'b1;
        tick(1);

        $display("[TB] basic job, count 3, one winning nonce");
        storeMode = 1;
        winNonce  = 64'h2_c914_6afb;
        applyStimulus(blobA, 64'h24a6_7fcd, 64'h2_c914_6afa, 32'd3);
        checkOutput("aLoad1",   576'(hash_load_o),   576'(1'b1));
        checkOutput("aNonce1",  576'(hash_nonce_o),  576'(64'h2_c914_6afa));
        checkOutput("aReady",   576'(job_ready_o),   576'(1'b0));
        checkOutput("aBusy",    576'(busy_o),        576'(1'b1));
        checkOutput("aBlob",    576'(hash_blob_o),   blobA);
        checkOutput("aTarget",  576'(hash_target_o), 576'(64'h24a6_7fcd));
        tick(1);
        checkOutput("aLoadGap", 576'(hash_load_o),   576'(1'b0));
        checkOutput("aIssued1", 576'(hash_issued_o), 576'(32'd1));
        tick(3);
        checkOutput("aLoad2",   576'(hash_load_o),   576'(1'b1));
        checkOutput("aNonce2",  576'(hash_nonce_o),  576'(64'h2_c914_6afb));
        tick(4);
        checkOutput("aLoad3",   576'(hash_load_o),   576'(1'b1));
        checkOutput("aNonce3",  576'(hash_nonce_o),  576'(64'h2_c914_6afc));
        tick(1);
        checkOutput("aIssued3", 576'(hash_issued_o), 576'(32'd3));
        checkOutput("aNoLoad4", 576'(hash_load_o),   576'(1'b0));
        tick(19);
        checkOutput("aResEarly", 576'(res_valid_o),  576'(1'b0));
        tick(1);
        checkOutput("aResValid", 576'(res_valid_o),  576'(1'b1));
        checkOutput("aResNonce", 576'(res_nonce_o),  576'(64'h2_c914_6afb));
        checkOutput("aResHash",  576'(res_hash_o),   576'(hashOf(64'h2_c914_6afb)));
        tick(3);
        checkOutput("aDoneEarly", 576'(job_done_o),  576'(1'b0));
        checkOutput("aResHeld",   576'(res_valid_o), 576'(1'b1));
        tick(1);
        checkOutput("aDone",      576'(job_done_o),  576'(1'b1));
        tick(1);
        checkOutput("aDoneOnce",  576'(job_done_o),  576'(1'b0));
        checkOutput("aIdle",      576'(busy_o),      576'(1'b0));
        res_ready_i = 1'b1;
        tick(1);
        res_ready_i = 1'b0;
        checkOutput("aPopped",    576'(res_valid_o), 576'(1'b0));

        $display("[TB] nonce wrap");
        storeMode = 0;
        applyStimulus(blobA, 64'h1234, 64'hFFFF_FFFF_FFFF_FFFE, 32'd3);
        checkOutput("wNonce1",  576'(hash_nonce_o),  576'(64'hFFFF_FFFF_FFFF_FFFE));
        checkOutput("wTarget",  576'(hash_target_o), 576'(64'h1234));
        checkOutput("wIssued0", 576'(hash_issued_o), 576'(32'd0));
        tick(4);
        checkOutput("wNonce2",  576'(hash_nonce_o),  576'(64'hFFFF_FFFF_FFFF_FFFF));
        tick(4);
        checkOutput("wLoad3",   576'(hash_load_o),   576'(1'b1));
        checkOutput("wNonce3",  576'(hash_nonce_o),  576'(64'h0));
        waitForDone(40, found);
        checkOutput("wDoneSeen", 576'(found),         576'(1'b1));
        checkOutput("wIssued3",  576'(hash_issued_o), 576'(32'd3));
        tick(1);

        $display("[TB] result FIFO overflow");
        storeMode = 2;
        applyStimulus(blobA, 64'h55, 64'h1000, 32'd6);
        tick(40);
        checkOutput("oNoOvfYet", 576'(res_overflow_o), 576'(1'b0));
        tick(1);
        checkOutput("oOverflow", 576'(res_overflow_o), 576'(1'b1));
        tick(4);
        checkOutput("oDone",     576'(job_done_o),     576'(1'b1));
        tick(1);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("oValid%0d", i), 576'(res_valid_o), 576'(1'b1));
            checkOutput($sformatf("oNonce%0d", i), 576'(res_nonce_o), 576'(64'h1000 + 64'(i)));
            checkOutput($sformatf("oHash%0d", i),  576'(res_hash_o),  576'(hashOf(64'h1000 + 64'(i))));
            res_ready_i = 1'b1;
            tick(1);
        end
        res_ready_i = 1'b0;
        checkOutput("oEmpty",  576'(res_valid_o),    576'(1'b0));
        checkOutput("oSticky", 576'(res_overflow_o), 576'(1'b1));

        $display("[TB] abort after second pulse");
        applyStimulus(blobA, 64'h77, 64'h500, 32'd100);
        tick(8);
        abort_i = 1'b1;
        #1;
        checkOutput("abNoPulse", 576'(hash_load_o), 576'(1'b0));
        tick(1);
        abort_i = 1'b0;
        checkOutput("abIssued",  576'(hash_issued_o), 576'(32'd2));
        checkOutput("abBusy",    576'(busy_o),        576'(1'b1));
        loads = 0;
        for (int i = 0; i < 23; i++) begin
            if (hash_load_o) loads++;
            tick(1);
        end
        checkOutput("abNoLoads",   576'(loads),      576'(0));
        checkOutput("abDoneEarly", 576'(job_done_o), 576'(1'b0));
        tick(1);
        checkOutput("abDone",      576'(job_done_o), 576'(1'b1));
        tick(1);
        checkOutput("abRes0",   576'(res_nonce_o), 576'(64'h500));
        checkOutput("abHash0",  576'(res_hash_o),  576'(hashOf(64'h500)));
        res_ready_i = 1'b1;
        tick(1);
        checkOutput("abRes1",   576'(res_nonce_o), 576'(64'h501));
        tick(1);
        res_ready_i = 1'b0;
        checkOutput("abEmpty",  576'(res_valid_o), 576'(1'b0));

        $display("[TB] stray store while idle");
        forceStore = 1'b1;
        tick(1);
        forceStore = 1'b0;
        checkOutput("strayIgnored", 576'(res_valid_o), 576'(1'b0));
        tick(1);
        checkOutput("strayStill",   576'(res_valid_o), 576'(1'b0));

        $display("[TB] zero-count job");
        applyStimulus(blobA, 64'h99, 64'h900, 32'd0);
        checkOutput("zDone",  576'(job_done_o),  576'(1'b1));
        checkOutput("zLoad",  576'(hash_load_o), 576'(1'b0));
        checkOutput("zBusy",  576'(busy_o),      576'(1'b1));
        tick(1);
        checkOutput("zDoneOnce", 576'(job_done_o),  576'(1'b0));
        checkOutput("zReady",    576'(job_ready_o), 576'(1'b1));

        $display("[TB] reset mid-run");
        applyStimulus(blobA, 64'hAB, 64'h700, 32'd10);
        tick(4);
        checkOutput("gLoad2",  576'(hash_nonce_o), 576'(64'h701));
        rst_n = 1'b0;
        #1;
        checkOutput("gBusy",     576'(busy_o),         576'(1'b0));
        checkOutput("gReady",    576'(job_ready_o),    576'(1'b1));
        checkOutput("gLoad",     576'(hash_load_o),    576'(1'b0));
        checkOutput("gNonce",    576'(hash_nonce_o),   576'(64'h0));
        checkOutput("gBlob",     576'(hash_blob_o),    576'(0));
        checkOutput("gIssued",   576'(hash_issued_o),  576'(32'd0));
        checkOutput("gOverflow", 576'(res_overflow_o), 576'(1'b0));
        #2;
        rst_n = 1'b1;
        tick(2);
        checkOutput("gStayIdle", 576'(busy_o), 576'(1'b0));

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
